// File: rtl/argon_regfile_if.sv
// Bundled read-request, read-response, write and reservation signals for argon_regfile_mp.
// The master modport is the client (pipeline/testbench); the slave modport is the register file.
interface argon_regfile_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic                  i_rd_valid;
  logic [IDX_W-1:0]      i_rd_idxA;
  logic [IDX_W-1:0]      i_rd_idxB;
  logic                  o_rd_ready;

  logic                  o_resp_valid;
  logic [DATA_WIDTH-1:0] o_resp_dataA;
  logic [DATA_WIDTH-1:0] o_resp_dataB;
  logic                  i_resp_ready;

  logic                  i_wr_valid;
  logic [IDX_W-1:0]      i_wr_idx;
  logic [DATA_WIDTH-1:0] i_wr_data;

  logic                  i_rsv_valid;
  logic [IDX_W-1:0]      i_rsv_idx;
  logic                  o_rsv_ready;

  logic [NUM_REGS-1:0]   o_busy;

  modport slave (
    input  i_rd_valid, i_rd_idxA, i_rd_idxB, i_resp_ready,
    input  i_wr_valid, i_wr_idx, i_wr_data, i_rsv_valid, i_rsv_idx,
    output o_rd_ready, o_resp_valid, o_resp_dataA, o_resp_dataB,
    output o_rsv_ready, o_busy
  );

  modport master (
    output i_rd_valid, i_rd_idxA, i_rd_idxB, i_resp_ready,
    output i_wr_valid, i_wr_idx, i_wr_data, i_rsv_valid, i_rsv_idx,
    input  o_rd_ready, o_resp_valid, o_resp_dataA, o_resp_dataB,
    input  o_rsv_ready, o_busy
  );
endinterface

// File: rtl/argon_regfile_mp.sv
// Two-read/one-write register file with a pending-write scoreboard and a held read response.
// Define ARGON_REGFILE_BYPASS_EN to forward same-cycle write data to reads of that register.
module argon_regfile_mp #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  argon_regfile_if.slave    bus
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_a_q, resp_a_d;
  logic [DATA_WIDTH-1:0] resp_b_q, resp_b_d;

  logic                  wr_en;
  logic                  rd_accept;
  logic                  rsv_accept;
  logic                  srcbusy_a, srcbusy_b;
  logic [DATA_WIDTH-1:0] stored_a, stored_b;
  logic [DATA_WIDTH-1:0] op_a, op_b;

  assign wr_en    = bus.i_wr_valid && (bus.i_wr_idx != '0);
  assign stored_a = (bus.i_rd_idxA == '0) ? '0 : regs_q[bus.i_rd_idxA];
  assign stored_b = (bus.i_rd_idxB == '0) ? '0 : regs_q[bus.i_rd_idxB];

`ifdef ARGON_REGFILE_BYPASS_EN
  logic fwd_a, fwd_b;
  assign fwd_a     = wr_en && (bus.i_wr_idx == bus.i_rd_idxA);
  assign fwd_b     = wr_en && (bus.i_wr_idx == bus.i_rd_idxB);
  assign srcbusy_a = busy_q[bus.i_rd_idxA] && !fwd_a;
  assign srcbusy_b = busy_q[bus.i_rd_idxB] && !fwd_b;
  assign op_a      = fwd_a ? bus.i_wr_data : stored_a;
  assign op_b      = fwd_b ? bus.i_wr_data : stored_b;
`else
  assign srcbusy_a = busy_q[bus.i_rd_idxA];
  assign srcbusy_b = busy_q[bus.i_rd_idxB];
  assign op_a      = stored_a;
  assign op_b      = stored_b;
`endif

  // Ready depends only on state, indices and i_resp_ready, never on i_rd_valid.
  assign bus.o_rd_ready  = !srcbusy_a && !srcbusy_b && (!resp_valid_q || bus.i_resp_ready);
  assign bus.o_rsv_ready = !busy_q[bus.i_rsv_idx];
  assign rd_accept       = bus.i_rd_valid && bus.o_rd_ready;
  assign rsv_accept      = bus.i_rsv_valid && bus.o_rsv_ready && (bus.i_rsv_idx != '0);

  assign bus.o_busy       = busy_q;
  assign bus.o_resp_valid = resp_valid_q;
  assign bus.o_resp_dataA = resp_a_q;
  assign bus.o_resp_dataB = resp_b_q;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = (wr_en && (bus.i_wr_idx == IDX_W'(i))) ? bus.i_wr_data : regs_q[i];
    end
    regs_d[0] = '0;

    // Clear-then-set so a reservation landing with the write keeps the register busy.
    busy_d = busy_q;
    if (wr_en)      busy_d[bus.i_wr_idx]  = 1'b0;
    if (rsv_accept) busy_d[bus.i_rsv_idx] = 1'b1;
    busy_d[0] = 1'b0;

    resp_valid_d = resp_valid_q;
    resp_a_d     = resp_a_q;
    resp_b_d     = resp_b_q;
    if (rd_accept) begin
      resp_valid_d = 1'b1;
      resp_a_d     = op_a;
      resp_b_d     = op_b;
    end else if (resp_valid_q && bus.i_resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) regs_q[gi] <= '0;
        else         regs_q[gi] <= regs_d[gi];
      end
    end
  endgenerate

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      busy_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_a_q     <= '0;
      resp_b_q     <= '0;
    end else begin
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_a_q     <= resp_a_d;
      resp_b_q     <= resp_b_d;
    end
  end
endmodule
